// File: rtl/rs232_response_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rs232_response_serializer
//  Purpose  : Captures a packed multi-byte response from the RS-232 command
//             processor and streams it MSB byte first to the single-byte
//             UART transmitter over a valid/ready handshake. An optional
//             idle gap is inserted after every accepted byte.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            in   system clock
//    reset            in   asynchronous, active-high reset
//    tx_bytes         in   packed response, first byte in the top 8 bits
//    tx_num_bytes     in   valid byte count, counted from the top of tx_bytes
//    tx_valid         in   request level; a rising edge starts one response
//    uart_ready       in   UART TX accepts a byte this cycle
//    uart_data        out  byte presented to UART TX
//    uart_data_valid  out  uart_data valid (transfer on valid & ready)
//    busy             out  response in progress
//    done             out  one-cycle pulse after the last byte (and its gap)
//    overrun          out  one-cycle pulse: request edge dropped while busy
// ============================================================================
module rs232_response_serializer #(
  parameter int MAX_BYTES  = 11,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MAX_BYTES*8-1:0] tx_bytes,
  input  logic [3:0]             tx_num_bytes,
  input  logic                   tx_valid,
  input  logic                   uart_ready,
  output logic [7:0]             uart_data,
  output logic                   uart_data_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int          BUF_W      = MAX_BYTES * 8;
  localparam logic [3:0]  MAX_COUNT  = 4'(MAX_BYTES);
  localparam bit          HAS_GAP    = (GAP_CYCLES > 0);
  // The gap counter counts down to zero inclusive, so it is loaded with N-1.
  localparam logic [15:0] GAP_RELOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [BUF_W-1:0] buffer;
  logic [BUF_W-1:0] buffer_next;
  logic [3:0]       count;
  logic [3:0]       count_next;
  logic [15:0]      gap_count;
  logic [15:0]      gap_next;
  logic             tx_valid_last;
  logic             req_edge;
  logic             overrun_next;

  // tx_valid_last resets to 0, so a request already high when reset
  // releases is seen as a fresh edge.
  assign req_edge = tx_valid & ~tx_valid_last;

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    buffer_next  = buffer;
    count_next   = count;
    gap_next     = gap_count;
    overrun_next = 1'b0;

    case (state)
      ST_IDLE: begin
        // A zero-length request is silently ignored.
        if (req_edge && (tx_num_bytes != 4'd0)) begin
          buffer_next = tx_bytes;
          count_next  = (tx_num_bytes > MAX_COUNT) ? MAX_COUNT : tx_num_bytes;
          state_next  = ST_SEND;
        end
      end

      ST_SEND: begin
        // uart_data_valid is high for the whole of SEND, so ready alone
        // marks a transfer. Without it everything holds, keeping data stable.
        if (uart_ready) begin
          buffer_next = buffer << 8;
          count_next  = count - 4'd1;
          if (HAS_GAP) begin
            gap_next   = GAP_RELOAD;
            state_next = ST_GAP;
          end else if (count == 4'd1) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        if (gap_count == 16'd0) begin
          state_next = (count != 4'd0) ? ST_SEND : ST_DONE;
        end else begin
          gap_next = gap_count - 16'd1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Requests arriving mid-response are dropped and flagged.
    if (req_edge && (state != ST_IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs. Outputs are loaded from the next-state
  // values so they line up with the state they describe with no extra delay.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buffer          <= '0;
      count           <= 4'd0;
      gap_count       <= 16'd0;
      tx_valid_last   <= 1'b0;
      uart_data       <= 8'h00;
      uart_data_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      buffer          <= buffer_next;
      count           <= count_next;
      gap_count       <= gap_next;
      tx_valid_last   <= tx_valid;
      uart_data_valid <= (state_next == ST_SEND);
      uart_data       <= (state_next == ST_SEND) ? buffer_next[BUF_W-1 -: 8] : 8'h00;
      busy            <= (state_next != ST_IDLE);
      done            <= (state_next == ST_DONE);
      overrun         <= overrun_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs232_response_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs232_response_serializer
//  Purpose  : Self-checking bench for rs232_response_serializer. Two
//             instances (no gap / 4-cycle gap) share all stimulus; each
//             response is recorded and compared against a transaction-level
//             model of the byte order and handshake timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs232_response_serializer;

  localparam int MAXB   = 11;
  localparam int GAP1   = 4;
  localparam int LEN    = 1024;
  localparam int BUDGET = 900;

  logic              clock;
  logic              reset;
  logic [MAXB*8-1:0] tx_bytes;
  logic [3:0]        tx_num_bytes;
  logic              tx_valid;
  logic              uart_ready;

  logic [7:0] data_g0, data_g4;
  logic       valid_g0, valid_g4, busy_g0, busy_g4, done_g0, done_g4, ovr_g0, ovr_g4;

  rs232_response_serializer #(.MAX_BYTES(MAXB), .GAP_CYCLES(0)) dut_g0 (
    .clock(clock), .reset(reset), .tx_bytes(tx_bytes), .tx_num_bytes(tx_num_bytes),
    .tx_valid(tx_valid), .uart_ready(uart_ready), .uart_data(data_g0),
    .uart_data_valid(valid_g0), .busy(busy_g0), .done(done_g0), .overrun(ovr_g0)
  );

  rs232_response_serializer #(.MAX_BYTES(MAXB), .GAP_CYCLES(GAP1)) dut_g4 (
    .clock(clock), .reset(reset), .tx_bytes(tx_bytes), .tx_num_bytes(tx_num_bytes),
    .tx_valid(tx_valid), .uart_ready(uart_ready), .uart_data(data_g4),
    .uart_data_valid(valid_g4), .busy(busy_g4), .done(done_g4), .overrun(ovr_g4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Per-cycle recording, index 0 = cycle in which the request is applied.
  logic [7:0] rec_data  [2][LEN];
  logic       rec_valid [2][LEN];
  logic       rec_busy  [2][LEN];
  logic       rec_done  [2][LEN];
  logic       rec_ovr   [2][LEN];
  logic       rec_rdy   [LEN];

  task automatic sample(input int i);
    rec_data[0][i]  = data_g0;  rec_data[1][i]  = data_g4;
    rec_valid[0][i] = valid_g0; rec_valid[1][i] = valid_g4;
    rec_busy[0][i]  = busy_g0;  rec_busy[1][i]  = busy_g4;
    rec_done[0][i]  = done_g0;  rec_done[1][i]  = done_g4;
    rec_ovr[0][i]   = ovr_g0;   rec_ovr[1][i]   = ovr_g4;
  endtask

  // mode: 0 ready always, 1 ready 50%, 2 ready one cycle in four, 3 ready 75%
  // inject: drop and re-raise tx_valid so a second edge lands in cycle 2
  // via_reset: the request is already high; releasing reset creates the edge
  task automatic run_txn(input string name, input int mode, input bit inject, input bit via_reset);
    int n, last, t, c, exp_valid, exp_done, exp_over;
    int nx, vc, dc, df, bc, oc, uns;
    int exp_cyc [16];
    int obs_cyc [16];
    int obs_dat [16];
    int gaps [2];
    bit finished;
    gaps[0] = 0;
    gaps[1] = GAP1;
    n = (int'(tx_num_bytes) > MAXB) ? MAXB : int'(tx_num_bytes);
    if (!via_reset) begin
      tx_valid = 1'b0;
      @(negedge clock);
    end
    finished = 1'b0;
    last     = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clock);
      sample(i);
      case (mode)
        0:       uart_ready = 1'b1;
        1:       uart_ready = 1'($urandom_range(0, 1));
        2:       uart_ready = ((i % 4) == 3);
        default: uart_ready = ($urandom_range(0, 3) != 0);
      endcase
      rec_rdy[i] = uart_ready;
      if (i == 0) begin
        if (via_reset) reset = 1'b0;
        else           tx_valid = 1'b1;
      end
      if (inject && i == 1) tx_valid = 1'b0;
      if (inject && i == 2) tx_valid = 1'b1;
      last = i;
      if (i >= 2 && !busy_g0 && !busy_g4) begin
        finished = 1'b1;
        break;
      end
    end
    check({name, " finished in budget"}, int'(finished), 1);

    for (int d = 0; d < 2; d++) begin
      // Model: byte b is offered from cycle t until the first ready cycle c,
      // the next byte is offered GAP cycles after c+1, done follows the last.
      t = 1;
      exp_valid = 0;
      for (int b = 0; b < n; b++) begin
        c = t;
        while (c < last && !rec_rdy[c]) c++;
        exp_cyc[b] = c;
        exp_valid += c - t + 1;
        t = c + 1 + gaps[d];
      end
      exp_done = t;
      exp_over = (inject && exp_done >= 2) ? 1 : 0;

      nx = 0; vc = 0; dc = 0; df = -1; bc = 0; oc = 0; uns = 0;
      for (int i = 0; i <= last; i++) begin
        if (rec_valid[d][i]) vc++;
        if (rec_valid[d][i] && rec_rdy[i]) begin
          if (nx < 16) begin
            obs_cyc[nx] = i;
            obs_dat[nx] = int'(rec_data[d][i]);
          end
          nx++;
        end
        if (rec_valid[d][i] && !rec_rdy[i] && i < last &&
            (!rec_valid[d][i+1] || rec_data[d][i+1] != rec_data[d][i])) uns++;
        if (rec_done[d][i]) begin
          dc++;
          if (df < 0) df = i;
        end
        if (rec_busy[d][i]) bc++;
        if (rec_ovr[d][i])  oc++;
      end

      check($sformatf("%s g%0d byte count", name, gaps[d]), nx, n);
      for (int b = 0; b < n && b < nx && b < 16; b++) begin
        check($sformatf("%s g%0d byte%0d data", name, gaps[d], b), obs_dat[b],
              int'(tx_bytes[(MAXB-1-b)*8 +: 8]));
        check($sformatf("%s g%0d byte%0d cycle", name, gaps[d], b), obs_cyc[b], exp_cyc[b]);
      end
      check($sformatf("%s g%0d valid cycles", name, gaps[d]), vc, exp_valid);
      check($sformatf("%s g%0d hold violations", name, gaps[d]), uns, 0);
      check($sformatf("%s g%0d done pulses", name, gaps[d]), dc, 1);
      check($sformatf("%s g%0d done cycle", name, gaps[d]), df, exp_done);
      check($sformatf("%s g%0d busy cycles", name, gaps[d]), bc, exp_done);
      check($sformatf("%s g%0d overrun pulses", name, gaps[d]), oc, exp_over);
    end
  endtask

  // Runs idle cycles with current inputs, counting activity on both instances.
  task automatic quiet(input int ncyc, output int vc, output int dc, output int bc);
    vc = 0; dc = 0; bc = 0;
    uart_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      vc += int'(valid_g0) + int'(valid_g4);
      dc += int'(done_g0) + int'(done_g4);
      bc += int'(busy_g0) + int'(busy_g4);
    end
  endtask

  task automatic randomize_bytes();
    for (int b = 0; b < MAXB; b++) tx_bytes[b*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, dc, bc;
    reset        = 1'b1;
    tx_valid     = 1'b0;
    tx_num_bytes = 4'd0;
    tx_bytes     = '0;
    uart_ready   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset state g0", int'({valid_g0, busy_g0, done_g0, ovr_g0, data_g0}), 0);
    check("reset state g4", int'({valid_g4, busy_g4, done_g4, ovr_g4, data_g4}), 0);
    reset = 1'b0;
    @(negedge clock);

    // "resp\r"
    tx_bytes     = {8'h72, 8'h65, 8'h73, 8'h70, 8'h0D, {6{8'h00}}};
    tx_num_bytes = 4'd5;
    run_txn("resp", 0, 1'b0, 1'b0);
    run_txn("resp slow ready", 2, 1'b0, 1'b0);
    run_txn("resp overrun", 0, 1'b1, 1'b0);

    // "0123ABCD\r"
    tx_bytes     = {8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, {2{8'h00}}};
    tx_num_bytes = 4'd9;
    run_txn("digits", 0, 1'b0, 1'b0);

    // zero-length request
    tx_valid     = 1'b0;
    tx_num_bytes = 4'd0;
    @(negedge clock);
    tx_valid = 1'b1;
    quiet(20, vc, dc, bc);
    check("num0 valid cycles", vc, 0);
    check("num0 done pulses", dc, 0);
    check("num0 busy cycles", bc, 0);

    // count above buffer depth is clamped
    randomize_bytes();
    tx_num_bytes = 4'd15;
    run_txn("num15", 1, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      randomize_bytes();
      tx_num_bytes = 4'($urandom_range(1, 15));
      run_txn($sformatf("rand%0d", k), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // reset mid-response, then restart with the request still high
    randomize_bytes();
    tx_num_bytes = 4'd7;
    uart_ready   = 1'b1;
    tx_valid     = 1'b0;
    @(negedge clock);
    tx_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("pre-reset g0 valid", int'(valid_g0), 1);
    check("pre-reset g0 data", int'(data_g0), int'(tx_bytes[(MAXB-3)*8 +: 8]));
    reset = 1'b1;
    #1;
    check("reset abort g0", int'({valid_g0, busy_g0, done_g0, ovr_g0, data_g0}), 0);
    check("reset abort g4", int'({valid_g4, busy_g4, done_g4, ovr_g4, data_g4}), 0);
    repeat (3) @(negedge clock);
    run_txn("after reset", 0, 1'b0, 1'b1);
    quiet(20, vc, dc, bc);
    check("held request valid cycles", vc, 0);
    check("held request busy cycles", bc, 0);
    tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
